regfile_wb_arbiter: RTL

- Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU) and B (load unit).
- Each requester has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs into a registered write port (rf_we/rf_addr/rf_wdata) that connects directly to the register file's WriteEnable/address/WriteData.
- Exports a pending-write bitmap so issue logic can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (A = ALU, B = load unit), the
// register file write port and the hazard/status outputs.
//   master : requester side (drives valid/addr/data, observes everything else)
//   slave  : arbiter side
`timescale 1ns/1ps
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic                     a_valid;
  logic                     a_ready;
  logic [ADDR_W-1:0]        a_addr;
  logic [DATA_W-1:0]        a_data;
  logic                     b_valid;
  logic                     b_ready;
  logic [ADDR_W-1:0]        b_addr;
  logic [DATA_W-1:0]        b_data;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_addr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [(2**ADDR_W)-1:0]   pending_mask;
  logic                     busy;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, rf_we, rf_addr, rf_wdata, pending_mask, busy
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, rf_we, rf_addr, rf_wdata, pending_mask, busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two requester FIFOs (A = ALU, B = load
// unit) drained into one registered write port, one write per cycle.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   bus (slave)  a_valid/a_ready/a_addr/a_data, b_valid/b_ready/b_addr/b_data,
//                rf_we/rf_addr/rf_wdata (registered write port),
//                pending_mask (registers with a queued or in-flight write),
//                busy (any FIFO non-empty or rf_we high)
// Build option: define WB_ARB_FIXED_PRIO_EN to give A strict priority over B
// instead of round-robin.
`timescale 1ns/1ps
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 2**ADDR_W;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  // Index 0 = requester A, index 1 = requester B.
  logic [ADDR_W-1:0] fifo_addr_q [2][FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [2][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [2][FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [2][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

`ifndef WB_ARB_FIXED_PRIO_EN
  src_e              last_grant_q, last_grant_d;
`endif

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_addr  [2];
  logic [DATA_W-1:0] in_data  [2];
  logic              ready    [2];
  logic              push     [2];
  logic              nonempty [2];
  logic              pop      [2];
  logic [NREG-1:0]   pending;

  // Handshake and FIFO occupancy
  always_comb begin
    in_valid[0] = bus.a_valid;
    in_addr[0]  = bus.a_addr;
    in_data[0]  = bus.a_data;
    in_valid[1] = bus.b_valid;
    in_addr[1]  = bus.b_addr;
    in_data[1]  = bus.b_data;
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i]    = !rst && (cnt_q[i] < CNT_W'(FIFO_DEPTH));
      // Writes to x0 complete the handshake but are dropped here.
      push[i]     = in_valid[i] && ready[i] && (in_addr[i] != '0);
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  // Arbitration
  always_comb begin
    pop[0] = 1'b0;
    pop[1] = 1'b0;
`ifdef WB_ARB_FIXED_PRIO_EN
    pop[0] = nonempty[0];
    pop[1] = nonempty[1] && !nonempty[0];
`else
    last_grant_d = last_grant_q;
    if (nonempty[0] && nonempty[1]) begin
      // Pointer only advances on contended grants.
      if (last_grant_q == SRC_B) begin
        pop[0]       = 1'b1;
        last_grant_d = SRC_A;
      end else begin
        pop[1]       = 1'b1;
        last_grant_d = SRC_B;
      end
    end else begin
      pop[0] = nonempty[0];
      pop[1] = nonempty[1];
    end
`endif
  end

  // FIFO next state and write port load
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rf_we_d     = pop[0] || pop[1];
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        fifo_addr_d[i][wr_ptr_q[i]] = in_addr[i];
        fifo_data_d[i][wr_ptr_q[i]] = in_data[i];
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rf_addr_d   = fifo_addr_q[i][rd_ptr_q[i]];
        rf_wdata_d  = fifo_data_q[i][rd_ptr_q[i]];
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // Pending-write bitmap: every occupied FIFO slot plus the in-flight write.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        if (CNT_W'(j) < cnt_q[i]) begin
          pending[fifo_addr_q[i][PTR_W'(rd_ptr_q[i] + PTR_W'(j))]] = 1'b1;
        end
      end
    end
    if (rf_we_q) begin
      pending[rf_addr_q] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
          fifo_addr_q[i][j] <= '0;
          fifo_data_q[i][j] <= '0;
        end
      end
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
`ifndef WB_ARB_FIXED_PRIO_EN
      // "Last granted B" so that A wins the first contended cycle.
      last_grant_q <= SRC_B;
`endif
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
`ifndef WB_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.a_ready      = ready[0];
  assign bus.b_ready      = ready[1];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_addr      = rf_addr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.pending_mask = pending;
  assign bus.busy         = nonempty[0] || nonempty[1] || rf_we_q;

endmodule
